// File: rtl/spi_txn_sequencer_pkg.sv
// Shared types and constants for the SPI transaction sequencer slice.
package spi_txn_sequencer_pkg;

  localparam int SPI_ADDR_WIDTH = 8;
  localparam int SPI_MAX_BYTES  = 4;
  localparam int NBYTES_W       = 2;
  localparam int SPI_DATA_W     = 32;
  localparam int CMD_W          = 1 + NBYTES_W + SPI_ADDR_WIDTH + SPI_DATA_W;

  // Bit offsets of each field inside a flattened command word (read flag is the MSB).
  localparam int CMD_WDATA_LSB  = 0;
  localparam int CMD_ADDR_LSB   = CMD_WDATA_LSB + SPI_DATA_W;
  localparam int CMD_NBYTES_LSB = CMD_ADDR_LSB + SPI_ADDR_WIDTH;
  localparam int CMD_READ_BIT   = CMD_NBYTES_LSB + NBYTES_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LAUNCH   = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_RESP     = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic                      read;
    logic [NBYTES_W-1:0]       nbytes;
    logic [SPI_ADDR_WIDTH-1:0] addr;
    logic [SPI_DATA_W-1:0]     wdata;
  } spi_cmd_t;

endpackage

// File: rtl/spi_txn_sequencer_cmd_fifo.sv
// Single-clock command FIFO with show-ahead read data and wrap-bit pointers.
module spi_txn_sequencer_cmd_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Advance pointers; a full FIFO refuses pushes even when a pop happens the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array needs no reset; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues SPI commands and issues them one at a time to the SPI shift engine,
// returning read data on a valid/ready port and flagging a hung driver.
module spi_txn_sequencer
  import spi_txn_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int SPI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_read,
  input  logic [1:0]                cmd_nbytes,
  input  logic [7:0]                cmd_addr,
  input  logic [SPI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [SPI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [7:0]                rsp_addr,
  output logic                      drv_start,
  output logic                      drv_read,
  output logic [1:0]                drv_nbytes,
  output logic [7:0]                drv_address,
  output logic [SPI_DATA_WIDTH-1:0] drv_write_data,
  input  logic                      drv_busy,
  input  logic [SPI_DATA_WIDTH-1:0] drv_read_data,
  output logic                      idle,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  spi_cmd_t         wr_cmd;
  spi_cmd_t         head_cmd;
  logic [CMD_W-1:0] fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [CNT_W-1:0] busy_cnt;

  assign wr_cmd    = '{read: cmd_read, nbytes: cmd_nbytes, addr: cmd_addr, wdata: cmd_wdata};
  assign head_cmd  = fifo_rd_data;
  assign cmd_ready = !fifo_full;
  assign rsp_valid = (state == ST_RESP);
  assign drv_start = (state == ST_LAUNCH);
  assign idle      = fifo_empty && (state == ST_IDLE);

  spi_txn_sequencer_cmd_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (cmd_valid && cmd_ready),
    .wr_data(wr_cmd),
    .pop    (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; only one command is ever in flight, including its response.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !rsp_valid) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH:   state_nxt = ST_WAIT_ACT;
      ST_WAIT_ACT: state_nxt = drv_busy ? ST_ACTIVE : ST_IDLE;
      ST_ACTIVE: begin
        if (!drv_busy) state_nxt = drv_read ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the popped command; fields hold until the next pop so the driver can sample them.
  always_ff @(posedge clk) begin
    if (reset) begin
      drv_read       <= 1'b0;
      drv_nbytes     <= '0;
      drv_address    <= '0;
      drv_write_data <= '0;
    end else if (pop) begin
      drv_read       <= head_cmd.read;
      drv_nbytes     <= head_cmd.nbytes;
      drv_address    <= head_cmd.addr;
      drv_write_data <= head_cmd.wdata;
    end
  end

  // Capture read data on the falling edge of busy, tagged with the command's address.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else if ((state == ST_ACTIVE) && !drv_busy && drv_read) begin
      rsp_rdata <= drv_read_data;
      rsp_addr  <= drv_address;
    end
  end

  // Sticky error: driver never went busy, or stayed busy for TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_WAIT_ACT) begin
        busy_cnt <= '0;
        if (!drv_busy) err_timeout <= 1'b1;
      end else if ((state == ST_ACTIVE) && drv_busy) begin
        if (busy_cnt != TO_LIMIT) busy_cnt <= busy_cnt + CNT_W'(1);
        if (busy_cnt == TO_LAST)  err_timeout <= 1'b1;
      end
    end
  end

endmodule
